// File: rtl/systema_btn_irq_master_if.sv
// rtl/systema_btn_irq_master_if.sv - Avalon-MM link between the button servicer and the PIO s1 slave
interface systema_btn_irq_master_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/systema_btn_irq_master.sv
// rtl/systema_btn_irq_master.sv - Avalon-MM initiator servicing the button PIO irq and publishing press events
module systema_btn_irq_master #(
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_i,
    systema_btn_irq_master_if.master   pio,
    output logic                       event_pulse_o,
    output logic                       btn_level_o,
    output logic [CNT_W-1:0]           event_count_o,
    output logic                       spurious_o,
    output logic                       busy_o
);
    localparam logic [2:0] S_MASK_WR = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_CAP_RD  = 3'd2;
    localparam logic [2:0] S_CAP_CLR = 3'd3;
    localparam logic [2:0] S_DAT_RD  = 3'd4;
    localparam logic [2:0] S_PUBLISH = 3'd5;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_CAP  = 2'd3;

    localparam int          CW   = $clog2(READ_LATENCY + 1) + 1;
    localparam logic [CW-1:0] LAST = CW'(READ_LATENCY);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             boot_q, boot_d;
    logic             mask_q, mask_d;
    logic [1:0]       addr_q, addr_d;
    logic             cs_q, cs_d;
    logic             wn_q, wn_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             evt_q, evt_d;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             spur_q, spur_d;
    logic             busy_q, busy_d;

    logic unused_rdata;
    assign unused_rdata = ^pio.readdata[31:1];

    // Bus registers are loaded from the next-state decision so each access lines up with its state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        boot_d  = boot_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        wdata_d = 32'd0;
        evt_d   = 1'b0;
        spur_d  = 1'b0;
        lvl_d   = lvl_q;
        count_d = count_q;
        case (state_q)
            S_MASK_WR: begin
                if (boot_q) begin
                    // one quiet bus cycle after reset before the first mask write
                    boot_d = 1'b0;
                end else if (cs_q && !wn_q) begin
                    mask_d  = wdata_q[0];
                    state_d = S_IDLE;
                end else begin
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = A_MASK;
                    wdata_d = {31'd0, enable_i};
                end
            end
            S_IDLE: begin
                if (enable_i != mask_q) begin
                    state_d = S_MASK_WR;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = A_MASK;
                    wdata_d = {31'd0, enable_i};
                end else if (pio.irq && mask_q) begin
                    state_d = S_CAP_RD;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    addr_d  = A_CAP;
                end
            end
            S_CAP_RD: begin
                if (cnt_q == LAST) begin
                    if (pio.readdata[0]) begin
                        state_d = S_CAP_CLR;
                        cs_d    = 1'b1;
                        wn_d    = 1'b0;
                        addr_d  = A_CAP;
                    end else begin
                        spur_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    cs_d  = 1'b1;
                end
            end
            S_CAP_CLR: begin
                state_d = S_DAT_RD;
                cnt_d   = '0;
                cs_d    = 1'b1;
                addr_d  = A_DATA;
            end
            S_DAT_RD: begin
                if (cnt_q == LAST) begin
                    lvl_d   = pio.readdata[0];
                    state_d = S_PUBLISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    cs_d  = 1'b1;
                end
            end
            S_PUBLISH: begin
                evt_d   = 1'b1;
                count_d = count_q + CNT_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_MASK_WR;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_MASK_WR;
            cnt_q   <= '0;
            boot_q  <= 1'b1;
            mask_q  <= 1'b0;
            addr_q  <= 2'd0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wdata_q <= 32'd0;
            evt_q   <= 1'b0;
            lvl_q   <= 1'b0;
            count_q <= '0;
            spur_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wdata_q <= wdata_d;
            evt_q   <= evt_d;
            lvl_q   <= lvl_d;
            count_q <= count_d;
            spur_q  <= spur_d;
            busy_q  <= busy_d;
        end
    end

    assign pio.address    = addr_q;
    assign pio.chipselect = cs_q;
    assign pio.write_n    = wn_q;
    assign pio.writedata  = wdata_q;
    assign event_pulse_o  = evt_q;
    assign btn_level_o    = lvl_q;
    assign event_count_o  = count_q;
    assign spurious_o     = spur_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_systema_btn_irq_master.sv
// tb/tb_systema_btn_irq_master.sv - self-checking bench with a button PIO model and bus transaction log
module tb_systema_btn_irq_master;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, enable, pin, force_irq;
    logic             event_pulse, btn_level, spurious, busy;
    logic [CNT_W-1:0] event_count;

    systema_btn_irq_master_if bus();

    systema_btn_irq_master #(.READ_LATENCY(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .pio(bus),
        .event_pulse_o(event_pulse), .btn_level_o(btn_level),
        .event_count_o(event_count), .spurious_o(spurious), .busy_o(busy)
    );

    // PIO model: falling-edge capture, clear-on-write, registered readdata
    logic pin_q = 1'b1, ecap = 1'b0, pmask = 1'b0;
    always @(posedge clk) begin
        pin_q <= pin;
        if (bus.chipselect && !bus.write_n && bus.address == 2'd3) ecap <= 1'b0;
        else if (pin_q && !pin) ecap <= 1'b1;
        if (bus.chipselect && !bus.write_n && bus.address == 2'd2) pmask <= bus.writedata[0];
        case (bus.address)
            2'd0:    bus.readdata <= {31'd0, pin};
            2'd2:    bus.readdata <= {31'd0, pmask};
            2'd3:    bus.readdata <= {31'd0, ecap};
            default: bus.readdata <= 32'd0;
        endcase
    end
    assign bus.irq = (ecap & pmask) | force_irq;

    function automatic logic [39:0] enc(input logic wr, input logic [1:0] a, input logic [31:0] d, input int len);
        logic [4:0] l;
        l = len[4:0];
        return {wr, a, d, l};
    endfunction

    // transaction log: one entry per write, one per read (with its held length)
    logic [39:0] blog[$];
    int          ev_cnt = 0, sp_cnt = 0, rd_len = 0;
    logic        rd_act = 1'b0;
    logic [1:0]  rd_addr = 2'd0;
    always @(posedge clk) begin
        if (event_pulse) ev_cnt <= ev_cnt + 1;
        if (spurious)    sp_cnt <= sp_cnt + 1;
        if (bus.chipselect && bus.write_n) begin
            if (rd_act && bus.address == rd_addr) rd_len <= rd_len + 1;
            else begin
                if (rd_act) blog.push_back(enc(1'b0, rd_addr, 32'd0, rd_len));
                rd_act  <= 1'b1;
                rd_addr <= bus.address;
                rd_len  <= 1;
            end
        end else begin
            if (rd_act) blog.push_back(enc(1'b0, rd_addr, 32'd0, rd_len));
            rd_act <= 1'b0;
            if (bus.chipselect && !bus.write_n) blog.push_back(enc(1'b1, bus.address, bus.writedata, 1));
        end
    end

    int checks = 0, errors = 0, exp_count = 0;

    task automatic test_reset();
        logic [39:0] exp_q[$];
        int n;
        rst = 1'b1; enable = 1'b1; pin = 1'b1; force_irq = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.chipselect, bus.write_n, busy, event_pulse, spurious, btn_level, bus.address} !== 8'b01100000) begin
            errors++;
            $display("FAIL reset_outputs: cs,wn,busy,evt,sp,lvl,addr=%b required 01100000",
                     {bus.chipselect, bus.write_n, busy, event_pulse, spurious, btn_level, bus.address});
        end
        checks++;
        if (event_count !== '0 || bus.writedata !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: count=%h wdata=%h required 0/0", event_count, bus.writedata);
        end
        blog.delete();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.chipselect !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle_idle: chipselect=%b required 0", bus.chipselect);
        end
        n = -1;
        for (int i = 0; i < 10 && n < 0; i++) begin
            @(negedge clk);
            if (!busy) n = i;
        end
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL reset_idle_timeout: busy=%b required 0 within 10 cycles", busy);
        end
        exp_q = '{enc(1'b1, 2'd2, 32'd1, 1)};
        checks++;
        if (blog.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_mask_write: %0d accesses, required %0d", blog.size(), exp_q.size());
        end else if (blog[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL reset_mask_write: entry %h required %h", blog[0], exp_q[0]);
        end
        checks++;
        if (pmask !== 1'b1 || event_count !== '0) begin
            errors++;
            $display("FAIL reset_end_state: pio mask=%b count=%h required 1/0", pmask, event_count);
        end
    endtask

    task automatic test_press();
        logic [39:0] exp_q[$];
        int n;
        logic tap;
        for (int p = 0; p < 8; p++) begin
            repeat ($urandom_range(20, 5)) @(negedge clk);
            tap = 1'($urandom_range(1, 0));
            blog.delete();
            pin = 1'b0;
            n = -1;
            for (int i = 1; i <= 40 && n < 0; i++) begin
                @(negedge clk);
                if (tap && i == 1) pin = 1'b1;
                if (event_pulse) n = i;
            end
            exp_count = (exp_count + 1) % (1 << CNT_W);
            // one cycle for PIO edge capture, then 7 cycles irq-to-event
            checks++;
            if (n != 8) begin
                errors++;
                $display("FAIL press_latency: pulse after %0d cycles, required 8", n);
            end
            checks++;
            if (event_count !== CNT_W'(exp_count)) begin
                errors++;
                $display("FAIL press_count: %h required %h", event_count, CNT_W'(exp_count));
            end
            checks++;
            if (btn_level !== tap) begin
                errors++;
                $display("FAIL press_level: %b required %b", btn_level, tap);
            end
            exp_q = '{enc(1'b0, 2'd3, 32'd0, 2), enc(1'b1, 2'd3, 32'd0, 1), enc(1'b0, 2'd0, 32'd0, 2)};
            checks++;
            if (blog.size() != exp_q.size()) begin
                errors++;
                $display("FAIL press_bus: %0d accesses, required %0d", blog.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++)
                    if (blog[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL press_bus: entry %0d %h required %h", i, blog[i], exp_q[i]);
                        break;
                    end
            end
            checks++;
            if (bus.irq !== 1'b0) begin
                errors++;
                $display("FAIL press_irq_cleared: irq=%b required 0", bus.irq);
            end
            repeat ($urandom_range(10, 0)) @(negedge clk);
            pin = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_spurious();
        int ev0, sp0;
        logic [39:0] exp_q[$];
        exp_q = '{enc(1'b0, 2'd3, 32'd0, 2)};
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(8, 2)) @(negedge clk);
            blog.delete();
            ev0 = ev_cnt; sp0 = sp_cnt;
            force_irq = 1'b1;
            @(negedge clk);
            force_irq = 1'b0;
            repeat (8) @(negedge clk);
            checks++;
            if (sp_cnt != sp0 + 1 || ev_cnt != ev0) begin
                errors++;
                $display("FAIL spurious_pulses: spurious=%0d events=%0d required 1/0", sp_cnt - sp0, ev_cnt - ev0);
            end
            checks++;
            if (event_count !== CNT_W'(exp_count)) begin
                errors++;
                $display("FAIL spurious_count: %h required %h", event_count, CNT_W'(exp_count));
            end
            checks++;
            if (blog.size() != 1 || blog[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL spurious_bus: %0d accesses, first %h, required 1 x %h", blog.size(),
                         (blog.size() > 0) ? blog[0] : 40'd0, exp_q[0]);
            end
        end
    endtask

    task automatic test_enable_mid();
        logic [39:0] exp_q[$];
        int ev0, n;
        ev0 = ev_cnt;
        blog.delete();
        pin = 1'b0;
        repeat ($urandom_range(6, 2)) @(negedge clk);
        enable = 1'b0;
        repeat (15) @(negedge clk);
        exp_count = (exp_count + 1) % (1 << CNT_W);
        checks++;
        if (ev_cnt != ev0 + 1 || event_count !== CNT_W'(exp_count)) begin
            errors++;
            $display("FAIL enmid_finish: events=%0d count=%h required 1/%h", ev_cnt - ev0, event_count, CNT_W'(exp_count));
        end
        exp_q = '{enc(1'b0, 2'd3, 32'd0, 2), enc(1'b1, 2'd3, 32'd0, 1), enc(1'b0, 2'd0, 32'd0, 2),
                  enc(1'b1, 2'd2, 32'd0, 1)};
        checks++;
        if (blog.size() != exp_q.size()) begin
            errors++;
            $display("FAIL enmid_bus: %0d accesses, required %0d", blog.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (blog[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL enmid_bus: entry %0d %h required %h", i, blog[i], exp_q[i]);
                    break;
                end
        end
        pin = 1'b1;
        repeat (3) @(negedge clk);
        blog.delete();
        ev0 = ev_cnt;
        pin = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (blog.size() != 0 || ev_cnt != ev0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL disabled_quiet: accesses=%0d events=%0d busy=%b required 0/0/0", blog.size(), ev_cnt - ev0, busy);
        end
        enable = 1'b1;
        n = -1;
        for (int i = 1; i <= 30 && n < 0; i++) begin
            @(negedge clk);
            if (event_pulse) n = i;
        end
        exp_count = (exp_count + 1) % (1 << CNT_W);
        checks++;
        if (n < 0 || event_count !== CNT_W'(exp_count) || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL reenable_event: after=%0d count=%h lvl=%b required event/%h/0", n, event_count,
                     btn_level, CNT_W'(exp_count));
        end
        exp_q = '{enc(1'b1, 2'd2, 32'd1, 1), enc(1'b0, 2'd3, 32'd0, 2), enc(1'b1, 2'd3, 32'd0, 1),
                  enc(1'b0, 2'd0, 32'd0, 2)};
        checks++;
        if (blog.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reenable_bus: %0d accesses, required %0d", blog.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (blog[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL reenable_bus: entry %0d %h required %h", i, blog[i], exp_q[i]);
                    break;
                end
        end
        pin = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_collapse();
        int ev0, k;
        enable = 1'b0;
        repeat (6) @(negedge clk);
        blog.delete();
        ev0 = ev_cnt;
        k = $urandom_range(5, 2);
        for (int e = 0; e < k; e++) begin
            pin = 1'b0;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            pin = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
        end
        pin = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (30) @(negedge clk);
        exp_count = (exp_count + 1) % (1 << CNT_W);
        checks++;
        if (ev_cnt != ev0 + 1 || event_count !== CNT_W'(exp_count)) begin
            errors++;
            $display("FAIL collapse_single_event: %0d edges gave %0d events, count=%h required 1/%h", k + 1,
                     ev_cnt - ev0, event_count, CNT_W'(exp_count));
        end
        checks++;
        if (blog.size() != 4) begin
            errors++;
            $display("FAIL collapse_bus: %0d accesses, required 4", blog.size());
        end
        pin = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        int n;
        for (int g = 0; g < 300 && exp_count != (1 << CNT_W) - 1; g++) begin
            pin = 1'b0;
            n = -1;
            for (int i = 1; i <= 20 && n < 0; i++) begin
                @(negedge clk);
                if (event_pulse) n = i;
            end
            exp_count = (exp_count + 1) % (1 << CNT_W);
            if (n < 0) begin
                checks++; errors++;
                $display("FAIL wrap_press_timeout: no event within 20 cycles, count=%h", event_count);
            end
            pin = 1'b1;
            repeat (2) @(negedge clk);
        end
        checks++;
        if (event_count !== {CNT_W{1'b1}}) begin
            errors++;
            $display("FAIL wrap_full: %h required %h", event_count, {CNT_W{1'b1}});
        end
        pin = 1'b0;
        n = -1;
        for (int i = 1; i <= 20 && n < 0; i++) begin
            @(negedge clk);
            if (event_pulse) n = i;
        end
        exp_count = (exp_count + 1) % (1 << CNT_W);
        checks++;
        if (n < 0 || event_count !== CNT_W'(exp_count)) begin
            errors++;
            $display("FAIL wrap_zero: after=%0d count=%h required event/%h", n, event_count, CNT_W'(exp_count));
        end
        pin = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ev0, n;
        ev0 = ev_cnt;
        pin = 1'b0;
        n = -1;
        for (int i = 1; i <= 20 && n < 0; i++) begin
            @(negedge clk);
            if (bus.chipselect && bus.write_n && bus.address == 2'd0) n = i;
        end
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL rstmid_no_data_read: data read not seen within 20 cycles");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.chipselect !== 1'b0 || busy !== 1'b1 || event_count !== '0) begin
            errors++;
            $display("FAIL rstmid_async: cs=%b busy=%b count=%h required 0/1/0", bus.chipselect, busy, event_count);
        end
        repeat (2) @(negedge clk);
        blog.delete();
        rst = 1'b0;
        exp_count = 0;
        @(negedge clk);
        checks++;
        if (bus.chipselect !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_first_cycle_idle: chipselect=%b required 0", bus.chipselect);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (blog.size() != 1 || blog[0] !== enc(1'b1, 2'd2, 32'd1, 1)) begin
            errors++;
            $display("FAIL rstmid_mask_reissue: %0d accesses, first %h, required 1 x %h", blog.size(),
                     (blog.size() > 0) ? blog[0] : 40'd0, enc(1'b1, 2'd2, 32'd1, 1));
        end
        checks++;
        if (ev_cnt != ev0 || event_count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: events=%0d count=%h busy=%b required 0/0/0", ev_cnt - ev0, event_count, busy);
        end
        pin = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_press();
        test_spurious();
        test_enable_mid();
        test_collapse();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
